// File: rtl/bsg_round_robin_2_to_1_merge_if.sv
// Handshake bundle for the 2-lane round-robin merge.
// The two striped input lanes share data_i/v_i/ready_o, and the merged
// output stream uses data_o/v_o/ready_i.
// The slave modport is the merge block; the master modport is whoever
// drives the lanes and consumes the merged stream.
interface bsg_round_robin_2_to_1_merge_if #(
  parameter int width_p = 32
);

  logic [2*width_p-1:0] data_i;
  logic [1:0]           v_i;
  logic [1:0]           ready_o;
  logic [width_p-1:0]   data_o;
  logic                 v_o;
  logic                 ready_i;

  modport slave (
    input  data_i,
    input  v_i,
    input  ready_i,
    output ready_o,
    output data_o,
    output v_o
  );

  modport master (
    output data_i,
    output v_i,
    output ready_i,
    input  ready_o,
    input  data_o,
    input  v_o
  );

endinterface

// File: rtl/bsg_round_robin_2_to_1_merge.sv
// Re-merges two round-robin striped lanes into one in-order stream.
// Each lane buffers up to els_p words. The output drains lane0, lane1,
// lane0, ... strictly alternately under the registered tail pointer.
// The output stalls if the lane whose turn it is happens to be empty.
//
// Optional feature: define BSG_RR_MERGE_BYPASS_EN to let a word arriving on
// an empty tail lane appear on the output in the same cycle (zero-latency
// pass-through). Without it, every output comes from registered storage.
module bsg_round_robin_2_to_1_merge #(
  parameter int width_p = 32,
  parameter int els_p   = 2
) (
  input logic clk_i,
  input logic reset_i,
  bsg_round_robin_2_to_1_merge_if.slave link
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = ptr_w + 1;
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(els_p);

  // Pointer advance; els_p is a power of two so natural overflow wraps it.
  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return p + ptr_w'(1);
  endfunction

  // Registered state
  logic               init_r;
  logic               tail_r;
  logic [ptr_w-1:0]   rptr_r [2];
  logic [ptr_w-1:0]   wptr_r [2];
  logic [cnt_w-1:0]   cnt_r  [2];
  logic [width_p-1:0] mem_r  [2][els_p];

  // Combinational helpers
  logic [width_p-1:0] lane_data [2];
  logic [width_p-1:0] head_data [2];
  logic [1:0]         full;
  logic [1:0]         empty;
  logic [1:0]         ready;
  logic [1:0]         enq;
  logic [1:0]         deq;
  logic               bypass;
  logic               xfer;
  logic               v;
  logic [width_p-1:0] data;

  // Per-lane status; ready is held low until the first edge after reset.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      lane_data[k] = link.data_i[k*width_p +: width_p];
      head_data[k] = mem_r[k][rptr_r[k]];
      full[k]      = (cnt_r[k] == full_cnt);
      empty[k]     = (cnt_r[k] == {cnt_w{1'b0}});
      ready[k]     = init_r & ~full[k];
    end
  end

  // Output select from the tail lane, plus the per-lane enqueue and dequeue strobes.
  always_comb begin
`ifdef BSG_RR_MERGE_BYPASS_EN
    bypass = init_r & empty[tail_r] & link.v_i[tail_r];
    data   = empty[tail_r] ? lane_data[tail_r] : head_data[tail_r];
`else
    bypass = 1'b0;
    data   = head_data[tail_r];
`endif
    v    = ~empty[tail_r] | bypass;
    xfer = v & link.ready_i;
    for (int k = 0; k < 2; k++) begin
      deq[k] = xfer & (tail_r == 1'(k)) & ~empty[k];
      // A word that bypasses straight to the output is never written.
      enq[k] = link.v_i[k] & ready[k]
             & ~(bypass & link.ready_i & (tail_r == 1'(k)));
    end
  end

  assign link.ready_o = ready;
  assign link.v_o     = v;
  assign link.data_o  = data;

  // Control state: init flag, tail pointer, FIFO pointers and counts.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      init_r <= 1'b0;
      tail_r <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        rptr_r[k] <= {ptr_w{1'b0}};
        wptr_r[k] <= {ptr_w{1'b0}};
        cnt_r[k]  <= {cnt_w{1'b0}};
      end
    end else begin
      init_r <= 1'b1;
      if (xfer) begin
        tail_r <= ~tail_r;
      end
      for (int k = 0; k < 2; k++) begin
        if (enq[k]) begin
          wptr_r[k] <= ptr_inc(wptr_r[k]);
        end
        if (deq[k]) begin
          rptr_r[k] <= ptr_inc(rptr_r[k]);
        end
        case ({enq[k], deq[k]})
          2'b10:   cnt_r[k] <= cnt_r[k] + cnt_w'(1);
          2'b01:   cnt_r[k] <= cnt_r[k] - cnt_w'(1);
          default: cnt_r[k] <= cnt_r[k];
        endcase
      end
    end
  end

  // Payload storage; contents are only meaningful between pointers, so no reset.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 2; k++) begin
      if (enq[k]) begin
        mem_r[k][wptr_r[k]] <= lane_data[k];
      end
    end
  end

endmodule

// File: tb/tb_bsg_round_robin_2_to_1_merge.sv
// Directed testbench for bsg_round_robin_2_to_1_merge (width_p=32, els_p=2).
// Inputs change 1 time unit after the rising edge.
// Outputs are sampled on the falling edge.
module tb_bsg_round_robin_2_to_1_merge;

  localparam int W = 32;

`ifdef BSG_RR_MERGE_BYPASS_EN
  localparam logic FIRST_V = 1'b1;
`else
  localparam logic FIRST_V = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  bsg_round_robin_2_to_1_merge_if #(.width_p(W)) bus ();

  bsg_round_robin_2_to_1_merge #(.width_p(W), .els_p(2)) dut (
    .clk_i   (clk),
    .reset_i (reset_n),
    .link    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] got   [$];
  logic [W-1:0] exp_q [$];
  logic         snap_v;
  logic [1:0]   snap_rdy;
  logic [W-1:0] snap_data;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", tag, act, req);
  endtask

  task automatic drive(input logic [1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1);
    bus.v_i    = v;
    bus.data_i = {d1, d0};
  endtask

  // One clock: sample at the falling edge, record transfers, then land 1 unit past the rising edge.
  task automatic cycle();
    @(negedge clk);
    snap_v    = bus.v_o;
    snap_rdy  = bus.ready_o;
    snap_data = bus.data_o;
    if (bus.v_o && bus.ready_i) got.push_back(bus.data_o);
    @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_word%0d", tag, i),
            (i < got.size()) ? 64'(got[i]) : 64'hDEAD_BEEF_DEAD_BEEF,
            64'(exp_q[i]));
    end
  endtask

  initial begin
    logic [W-1:0] w0 [10];
    logic [W-1:0] w1 [10];
    int i0;
    int i1;

    // T1: reset held with both lanes valid
    reset_n     = 1'b0;
    bus.ready_i = 1'b1;
    drive(2'b11, 32'hDD, 32'hEE);
    repeat (3) begin
      cycle();
      check("t1_v_in_reset", 64'(snap_v), 64'd0);
      check("t1_rdy_in_reset", 64'(snap_rdy), 64'd0);
    end
    reset_n = 1'b1;
    drive(2'b00, 32'h0, 32'h0);
    cycle();
    check("t1_rdy_before_edge", 64'(snap_rdy), 64'd0);
    cycle();
    check("t1_rdy_after_edge", 64'(snap_rdy), 64'd3);
    check("t1_v_after_edge", 64'(snap_v), 64'd0);

    // T2: ordered merge with ready_i high
    got.delete();
    drive(2'b01, 32'hA0, 32'h0);
    cycle();
    check("t2_first_v", 64'(snap_v), 64'(FIRST_V));
    drive(2'b10, 32'h0, 32'hB0); cycle();
    drive(2'b01, 32'hA1, 32'h0); cycle();
    drive(2'b10, 32'h0, 32'hB1); cycle();
    drive(2'b00, 32'h0, 32'h0);
    repeat (3) cycle();
    exp_q = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};
    check_stream("t2");

    // T3: lane1 fills while lane0 is empty; output must stall
    got.delete();
    drive(2'b10, 32'h0, 32'h21); cycle();
    check("t3_stall0", 64'(snap_v), 64'd0);
    drive(2'b10, 32'h0, 32'h22); cycle();
    check("t3_stall1", 64'(snap_v), 64'd0);
    drive(2'b00, 32'h0, 32'h0); cycle();
    check("t3_stall2", 64'(snap_v), 64'd0);
    check("t3_rdy_lane1_full", 64'(snap_rdy), 64'd1);
    drive(2'b01, 32'h11, 32'h0); cycle();
    drive(2'b01, 32'h12, 32'h0); cycle();
    drive(2'b00, 32'h0, 32'h0);
    repeat (5) cycle();
    exp_q = '{32'h11, 32'h21, 32'h12, 32'h22};
    check_stream("t3");

    // T4: lane0 fills under backpressure, then drains
    got.delete();
    bus.ready_i = 1'b0;
    drive(2'b01, 32'h31, 32'h0); cycle();
    check("t4_rdy_w0", 64'(snap_rdy), 64'd3);
    drive(2'b01, 32'h32, 32'h0); cycle();
    check("t4_rdy_w1", 64'(snap_rdy), 64'd3);
    drive(2'b01, 32'h33, 32'h0); cycle();
    check("t4_rdy_full", 64'(snap_rdy), 64'd2);
    check("t4_v_full", 64'(snap_v), 64'd1);
    check("t4_data_full", 64'(snap_data), 64'h31);
    bus.ready_i = 1'b1;
    cycle();
    check("t4_rdy_pop_cycle", 64'(snap_rdy), 64'd2);
    cycle();
    check("t4_rdy_after_pop", 64'(snap_rdy), 64'd3);
    drive(2'b10, 32'h0, 32'h41); cycle();
    drive(2'b10, 32'h0, 32'h42); cycle();
    drive(2'b10, 32'h0, 32'h43); cycle();
    drive(2'b00, 32'h0, 32'h0);
    repeat (6) cycle();
    exp_q = '{32'h31, 32'h41, 32'h32, 32'h42, 32'h33, 32'h43};
    check_stream("t4");

    // T5: random gaps and random ready_i; output must be the exact interleave
    got.delete();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      w0[i] = $urandom();
      w1[i] = $urandom();
      exp_q.push_back(w0[i]);
      exp_q.push_back(w1[i]);
    end
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 600 && got.size() < 20; c++) begin
      bus.v_i[0]          = (i0 < 10) && ($urandom_range(0, 3) != 0);
      bus.v_i[1]          = (i1 < 10) && ($urandom_range(0, 3) != 0);
      bus.data_i[W-1:0]   = w0[(i0 < 10) ? i0 : 9];
      bus.data_i[2*W-1:W] = w1[(i1 < 10) ? i1 : 9];
      bus.ready_i         = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.v_i[0] && bus.ready_o[0]) i0++;
      if (bus.v_i[1] && bus.ready_o[1]) i1++;
      if (bus.v_o && bus.ready_i) got.push_back(bus.data_o);
      @(posedge clk);
      #1;
    end
    drive(2'b00, 32'h0, 32'h0);
    bus.ready_i = 1'b1;
    check_stream("t5");

    // T6: reset pulsed between edges with words buffered in both lanes
    got.delete();
    bus.ready_i = 1'b0;
    drive(2'b11, 32'h51, 32'h52); cycle(); cycle();
    drive(2'b00, 32'h0, 32'h0); cycle();
    check("t6_v_before_reset", 64'(snap_v), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_v_async_drop", 64'(bus.v_o), 64'd0);
    check("t6_rdy_async_drop", 64'(bus.ready_o), 64'd0);
    @(posedge clk);
    #1;
    reset_n     = 1'b1;
    bus.ready_i = 1'b1;
    cycle();
    check("t6_v_release", 64'(snap_v), 64'd0);
    cycle();
    check("t6_v_discarded", 64'(snap_v), 64'd0);
    check("t6_rdy_back", 64'(snap_rdy), 64'd3);
    drive(2'b10, 32'h0, 32'h62); cycle();
    check("t6_v_wait_lane0", 64'(snap_v), 64'd0);
    drive(2'b01, 32'h61, 32'h0); cycle();
    drive(2'b00, 32'h0, 32'h0);
    repeat (4) cycle();
    exp_q = '{32'h61, 32'h62};
    check_stream("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
